demux_reg_param: RTL and testbench



---
 rtl/demux_reg_param_pkg.sv | 11 +
 rtl/demux_reg_param_if.sv | 29 ++
 rtl/demux_reg_param_canal.sv | 42 ++++
 rtl/demux_reg_param.sv | 81 ++++++++
 tb/tb_demux_reg_param.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/demux_reg_param_pkg.sv
// Shared constants and helpers for the registered 1-to-N demultiplexer.
package demux_reg_param_pkg;

    localparam int DROP_CNT_W = 8;

    // Low bit of channel k inside a flat N_OUT*WIDTH bus.
    function automatic int chan_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/demux_reg_param_if.sv
// Producer-side and consumer-side handshake bundle for demux_reg_param.
interface demux_reg_param_if #(
    parameter int WIDTH = 4,
    parameter int N_OUT = 2,
    parameter int SEL_W = 1
);
    import demux_reg_param_pkg::*;

    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic                   err_sel;
    logic [DROP_CNT_W-1:0]  drop_count;

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, err_sel, drop_count
    );

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, err_sel, drop_count
    );

endinterface

// File: rtl/demux_reg_param_canal.sv
// One-entry output channel: a load always wins over an unload, so a word
// can replace the one leaving in the same edge without a bubble.
module demux_canal #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux_reg_param.sv
// Registered 1-to-N demux: select decode, per-channel ready mux, and a
// saturating counter for words whose select names no channel.
module demux_reg_param
    import demux_reg_param_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N_OUT = 2,
    parameter int SEL_W = 1
) (
    input logic clk,
    input logic reset_L,
    demux_reg_param_if.slave bus
);

    logic [N_OUT-1:0]            load;
    logic [N_OUT-1:0]            ch_valid;
    logic [N_OUT-1:0][WIDTH-1:0] ch_data;
    logic [N_OUT*WIDTH-1:0]      out_flat;
    logic                        sel_ok;
    logic                        rdy;
    logic                        drop;

    logic                        err_q, err_d;
    logic [DROP_CNT_W-1:0]       drop_cnt_q, drop_cnt_d;

    // Only the addressed channel gates in_ready; out-of-range words always
    // pass so they can be discarded.
    always_comb begin
        load   = '0;
        sel_ok = 1'b0;
        rdy    = 1'b1;
        for (int k = 0; k < N_OUT; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                sel_ok  = 1'b1;
                rdy     = !ch_valid[k] || bus.out_ready[k];
                load[k] = bus.in_valid && rdy;
            end
        end
        drop = bus.in_valid && !sel_ok;
    end

    always_comb begin
        err_d      = drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_ch
        localparam int LO = chan_lo(k, WIDTH);

        demux_canal #(.WIDTH(WIDTH)) u_canal (
            .clk     (clk),
            .rst_n   (reset_L),
            .load_i  (load[k]),
            .data_i  (bus.in_data),
            .ready_i (bus.out_ready[k]),
            .valid_o (ch_valid[k]),
            .data_o  (ch_data[k])
        );

        assign out_flat[LO +: WIDTH] = ch_data[k];
    end

    assign bus.in_ready   = rdy;
    assign bus.out_valid  = ch_valid;
    assign bus.out_data   = out_flat;
    assign bus.err_sel    = err_q;
    assign bus.drop_count = drop_cnt_q;

endmodule

// File: tb/tb_demux_reg_param.sv
// Directed and scoreboard checks of demux_reg_param in three configurations.
module tb_demux_reg_param;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    demux_reg_param_if #(.WIDTH(4), .N_OUT(2), .SEL_W(1)) b2 ();
    demux_reg_param_if #(.WIDTH(4), .N_OUT(3), .SEL_W(2)) b3 ();
    demux_reg_param_if #(.WIDTH(8), .N_OUT(4), .SEL_W(2)) b4 ();

    demux_reg_param #(.WIDTH(4), .N_OUT(2), .SEL_W(1)) u2 (.clk(clk), .reset_L(reset_L), .bus(b2.slave));
    demux_reg_param #(.WIDTH(4), .N_OUT(3), .SEL_W(2)) u3 (.clk(clk), .reset_L(reset_L), .bus(b3.slave));
    demux_reg_param #(.WIDTH(8), .N_OUT(4), .SEL_W(2)) u4 (.clk(clk), .reset_L(reset_L), .bus(b4.slave));

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       sel;
        logic [3:0] data;
        logic       vld;
        logic [1:0] ordy;
        logic       rdy;
        logic [1:0] ov;
        logic [7:0] od;
    } vec_t;

    vec_t vt[11];

    logic [7:0] q[4][$];
    int         sent;
    int         cyc;
    logic [1:0] csel;
    logic [7:0] cdat;
    logic       cval;
    logic       exp_rdy;
    logic       accept;

    initial begin
        // sel, data, vld, ordy | in_ready, out_valid, out_data after edge
        vt[0]  = '{1'b0, 4'hA, 1'b1, 2'b00, 1'b1, 2'b01, 8'h0A};
        vt[1]  = '{1'b1, 4'h5, 1'b1, 2'b00, 1'b1, 2'b11, 8'h5A};
        vt[2]  = '{1'b0, 4'hC, 1'b1, 2'b00, 1'b0, 2'b11, 8'h5A};
        vt[3]  = '{1'b0, 4'hC, 1'b0, 2'b10, 1'b0, 2'b01, 8'h5A};
        vt[4]  = '{1'b1, 4'h3, 1'b1, 2'b00, 1'b1, 2'b11, 8'h3A};
        vt[5]  = '{1'b1, 4'h7, 1'b1, 2'b10, 1'b1, 2'b11, 8'h7A};
        vt[6]  = '{1'b1, 4'h9, 1'b0, 2'b11, 1'b1, 2'b00, 8'h7A};
        vt[7]  = '{1'b0, 4'hF, 1'b1, 2'b00, 1'b1, 2'b01, 8'h7F};
        vt[8]  = '{1'b0, 4'h1, 1'b1, 2'b01, 1'b1, 2'b01, 8'h71};
        vt[9]  = '{1'b1, 4'h2, 1'b1, 2'b01, 1'b1, 2'b10, 8'h21};
        vt[10] = '{1'b0, 4'h6, 1'b1, 2'b00, 1'b1, 2'b11, 8'h26};

        b2.in_data = '0; b2.in_sel = '0; b2.in_valid = 1'b0; b2.out_ready = '0;
        b3.in_data = '0; b3.in_sel = '0; b3.in_valid = 1'b0; b3.out_ready = '0;
        b4.in_data = '0; b4.in_sel = '0; b4.in_valid = 1'b0; b4.out_ready = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst ov2", 32'(b2.out_valid), 32'h0);
        check("rst od2", 32'(b2.out_data), 32'h0);
        check("rst ov3", 32'(b3.out_valid), 32'h0);
        check("rst err3", 32'(b3.err_sel), 32'h0);
        check("rst cnt3", 32'(b3.drop_count), 32'h0);
        @(negedge clk);
        reset_L = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            b2.in_sel = vt[i].sel; b2.in_data = vt[i].data;
            b2.in_valid = vt[i].vld; b2.out_ready = vt[i].ordy;
            #1;
            check($sformatf("vec%0d rdy", i), 32'(b2.in_ready), 32'(vt[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d ov", i), 32'(b2.out_valid), 32'(vt[i].ov));
            check($sformatf("vec%0d od", i), 32'(b2.out_data), 32'(vt[i].od));
            check($sformatf("vec%0d err", i), 32'(b2.err_sel), 32'h0);
        end

        // Asynchronous reset while both channels are full.
        @(negedge clk);
        b2.in_valid = 1'b0; b2.out_ready = 2'b00;
        #2 reset_L = 1'b0;
        #1;
        check("async rst ov", 32'(b2.out_valid), 32'h0);
        check("async rst od", 32'(b2.out_data), 32'h0);
        @(negedge clk);
        reset_L = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post rst ov", 32'(b2.out_valid), 32'h0);
        check("post rst od", 32'(b2.out_data), 32'h0);
        check("post rst rdy", 32'(b2.in_ready), 32'h1);

        // Out-of-range select on the 3-channel instance.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b3.in_sel = 2'd3; b3.in_data = 4'hE; b3.in_valid = 1'b1;
            #1;
            check($sformatf("drop%0d rdy", i), 32'(b3.in_ready), 32'h1);
            @(posedge clk);
            #1;
            check($sformatf("drop%0d err", i), 32'(b3.err_sel), 32'h1);
            check($sformatf("drop%0d cnt", i), 32'(b3.drop_count), 32'(i + 1));
            check($sformatf("drop%0d ov", i), 32'(b3.out_valid), 32'h0);
            check($sformatf("drop%0d od", i), 32'(b3.out_data), 32'h0);
        end
        @(negedge clk);
        b3.in_sel = 2'd2; b3.in_data = 4'h9;
        @(posedge clk);
        #1;
        check("valid after drop err", 32'(b3.err_sel), 32'h0);
        check("valid after drop cnt", 32'(b3.drop_count), 32'h3);
        check("valid after drop ov", 32'(b3.out_valid), 32'h4);
        check("valid after drop od", 32'(b3.out_data), 32'h900);
        @(negedge clk);
        b3.in_valid = 1'b0;
        b3.in_sel = 2'd3;
        #1;
        check("idle rdy invalid sel", 32'(b3.in_ready), 32'h1);
        @(posedge clk);
        #1;
        check("idle cnt", 32'(b3.drop_count), 32'h3);
        @(negedge clk);
        b3.in_valid = 1'b1;
        repeat (297) @(posedge clk);
        #1;
        check("sat cnt", 32'(b3.drop_count), 32'hFF);
        check("sat err", 32'(b3.err_sel), 32'h1);
        @(posedge clk);
        #1;
        check("sat cnt hold", 32'(b3.drop_count), 32'hFF);
        @(negedge clk);
        b3.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("err clear", 32'(b3.err_sel), 32'h0);
        @(negedge clk);
        #2 reset_L = 1'b0;
        #1;
        check("async rst cnt", 32'(b3.drop_count), 32'h0);
        check("async rst ov3", 32'(b3.out_valid), 32'h0);
        @(negedge clk);
        reset_L = 1'b1;

        // Random streaming against per-channel scoreboard queues.
        sent = 0; cyc = 0; cval = 1'b0; csel = '0; cdat = '0;
        while (sent < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!cval) begin
                cval = ($urandom_range(0, 3) != 0);
                csel = 2'($urandom_range(0, 3));
                cdat = 8'($urandom);
            end
            b4.in_valid = cval; b4.in_sel = csel; b4.in_data = cdat;
            b4.out_ready = 4'($urandom);
            #1;
            exp_rdy = (q[csel].size() == 0) || b4.out_ready[csel];
            check("stream rdy", 32'(b4.in_ready), 32'(exp_rdy));
            for (int k = 0; k < 4; k++) begin
                check($sformatf("stream ov%0d", k), 32'(b4.out_valid[k]), 32'(q[k].size() != 0));
                if (q[k].size() != 0 && b4.out_ready[k]) begin
                    check($sformatf("stream data%0d", k), 32'(b4.out_data[k*8 +: 8]), 32'(q[k][0]));
                    void'(q[k].pop_front());
                end
            end
            accept = cval && exp_rdy;
            @(posedge clk);
            if (accept) begin
                q[csel].push_back(cdat);
                sent++;
                cval = 1'b0;
            end
        end
        check("stream sent", 32'(sent), 32'd1000);

        @(negedge clk);
        b4.in_valid = 1'b0;
        b4.out_ready = 4'hF;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (q[k].size() != 0) begin
                check($sformatf("drain data%0d", k), 32'(b4.out_data[k*8 +: 8]), 32'(q[k][0]));
                void'(q[k].pop_front());
            end
        end
        @(posedge clk);
        #1;
        check("drain ov", 32'(b4.out_valid), 32'h0);
        for (int k = 0; k < 4; k++)
            check($sformatf("drain q%0d", k), 32'(q[k].size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
